// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rstseq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } rstseq_state_e;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rstseq_sync2.sv
// Two-flop synchronizer for an active-low asynchronous request; reset forces "asserted" (0).
module rstseq_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds all domain resets for MIN_ASSERT cycles, then releases them one at a time in index order.
// Optional RSTSEQ_REVERSE_ASSERT_EN: requests in RUN drain the domains in reverse order first.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_W       = 8,
    parameter int MIN_ASSERT  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ext_req_n,
    input  logic                   soft_req,
    input  logic [GAP_W-1:0]       gap_cycles,
    input  logic [NUM_DOMAINS-1:0] domain_mask,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_busy,
    output logic                   seq_done
);

    localparam int IDX_W = idx_w(NUM_DOMAINS);
    localparam int CNT_W = (MIN_ASSERT > 2) ? $clog2(MIN_ASSERT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
`ifdef RSTSEQ_REVERSE_ASSERT_EN
    localparam logic REV_EN = 1'b1;
`else
    localparam logic REV_EN = 1'b0;
`endif

    // A programmed gap of 0 behaves like 1; the counter compares against gap-1.
    function automatic logic [GAP_W-1:0] gap_lim_f(input logic [GAP_W-1:0] g);
        return (g == {GAP_W{1'b0}}) ? {GAP_W{1'b0}} : (g - GAP_ONE);
    endfunction

    rstseq_state_e          state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [GAP_W-1:0]       gap_q;
    logic [GAP_W-1:0]       lim_q;
    logic [NUM_DOMAINS-1:0] mask_q;
    logic                   fin_q;

    logic sync_n_s;
    logic req_total_s;
    logic abort_s;
    logic step_s;
    logic [IDX_W-1:0] idx_inc_s;

    rstseq_sync2 u_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (ext_req_n),
        .q_o    (sync_n_s)
    );

    assign req_total_s = (~sync_n_s) | soft_req;
    assign abort_s     = req_total_s & ((state_q == ST_RELEASE) | ((state_q == ST_RUN) & ~REV_EN));
    // A skipped domain advances at once; a released one waits out its gap.
    assign step_s      = (~mask_q[idx_q]) | (gap_q == lim_q);
    assign idx_inc_s   = idx_q + IDX_ONE;

`ifdef RSTSEQ_REVERSE_ASSERT_EN
    logic [IDX_W-1:0] idx_dec_s;
    assign idx_dec_s = idx_q - IDX_ONE;
`endif

    // Sequencer FSM with registered reset, busy and done outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            gap_q        <= {GAP_W{1'b0}};
            lim_q        <= {GAP_W{1'b0}};
            mask_q       <= {NUM_DOMAINS{1'b0}};
            fin_q        <= 1'b0;
            domain_rst_n <= {NUM_DOMAINS{1'b0}};
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            if (abort_s) begin
                state_q      <= ST_ASSERT;
                cnt_q        <= {CNT_W{1'b0}};
                fin_q        <= 1'b0;
                domain_rst_n <= {NUM_DOMAINS{1'b0}};
                seq_busy     <= 1'b1;
            end else begin
                case (state_q)
                    ST_ASSERT: begin
                        domain_rst_n <= {NUM_DOMAINS{1'b0}};
                        seq_busy     <= 1'b1;
                        if (req_total_s) begin
                            cnt_q <= {CNT_W{1'b0}};
                        end else if (cnt_q == CNT_END) begin
                            // Index 0 is handled on the entry edge itself
                            state_q         <= ST_RELEASE;
                            mask_q          <= domain_mask;
                            idx_q           <= {IDX_W{1'b0}};
                            fin_q           <= 1'b0;
                            gap_q           <= {GAP_W{1'b0}};
                            lim_q           <= gap_lim_f(gap_cycles);
                            domain_rst_n[0] <= domain_mask[0];
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_RELEASE: begin
                        if (fin_q) begin
                            state_q  <= ST_RUN;
                            seq_busy <= 1'b0;
                        end else if (step_s) begin
                            idx_q <= idx_inc_s;
                            gap_q <= {GAP_W{1'b0}};
                            lim_q <= gap_lim_f(gap_cycles);
                            if (mask_q[idx_inc_s]) begin
                                domain_rst_n[idx_inc_s] <= 1'b1;
                            end
                            if (idx_inc_s == LAST_IDX) begin
                                fin_q    <= 1'b1;
                                seq_done <= 1'b1;
                            end
                        end else begin
                            gap_q <= gap_q + GAP_ONE;
                        end
                    end
                    ST_RUN: begin
`ifdef RSTSEQ_REVERSE_ASSERT_EN
                        if (req_total_s) begin
                            state_q                <= ST_DRAIN;
                            idx_q                  <= LAST_IDX;
                            gap_q                  <= {GAP_W{1'b0}};
                            lim_q                  <= gap_lim_f(gap_cycles);
                            fin_q                  <= 1'b0;
                            domain_rst_n[LAST_IDX] <= 1'b0;
                            seq_busy               <= 1'b1;
                        end
`else
                        state_q <= ST_RUN;
`endif
                    end
`ifdef RSTSEQ_REVERSE_ASSERT_EN
                    ST_DRAIN: begin
                        if (fin_q) begin
                            state_q      <= ST_ASSERT;
                            cnt_q        <= {CNT_W{1'b0}};
                            domain_rst_n <= {NUM_DOMAINS{1'b0}};
                        end else if (step_s) begin
                            idx_q                   <= idx_dec_s;
                            gap_q                   <= {GAP_W{1'b0}};
                            lim_q                   <= gap_lim_f(gap_cycles);
                            domain_rst_n[idx_dec_s] <= 1'b0;
                            if (idx_dec_s == {IDX_W{1'b0}}) begin
                                fin_q <= 1'b1;
                            end
                        end else begin
                            gap_q <= gap_q + GAP_ONE;
                        end
                    end
`endif
                    default: begin
                        state_q      <= ST_ASSERT;
                        cnt_q        <= {CNT_W{1'b0}};
                        fin_q        <= 1'b0;
                        domain_rst_n <= {NUM_DOMAINS{1'b0}};
                        seq_busy     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table, hand-written corner sequences, random run vs a schedule model.
module tb_reset_sequencer;

    localparam int N   = 4;
    localparam int MIN = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ext_req_n = 1'b1;
    logic       soft_req = 1'b0;
    logic [7:0] gap_cycles = 8'd0;
    logic [3:0] domain_mask = 4'hF;
    logic [3:0] domain_rst_n;
    logic       seq_busy;
    logic       seq_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    reset_sequencer #(.NUM_DOMAINS(4), .GAP_W(8), .MIN_ASSERT(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ext_req_n    (ext_req_n),
        .soft_req     (soft_req),
        .gap_cycles   (gap_cycles),
        .domain_mask  (domain_mask),
        .domain_rst_n (domain_rst_n),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done)
    );

    // Reference model: a release schedule planned when the hold period ends.
    int         m_phase;
    int         m_c;
    int         m_t;
    int         rise_at [N];
    int         done_at;
    int         run_at;
    logic       m_s1, m_s2;
    logic [3:0] e_rst;
    logic       e_busy, e_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_c = 0; m_t = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        e_rst = 4'h0; e_busy = 1'b1; e_done = 1'b0;
    endtask

    task automatic model_plan();
        int t;
        int g;
        g = (gap_cycles == 8'd0) ? 1 : int'(gap_cycles);
        t = 0;
        for (int k = 0; k < N; k++) begin
            rise_at[k] = domain_mask[k] ? t : -1;
            if (k < N - 1) t += domain_mask[k] ? g : 1;
        end
        done_at = t;
        run_at  = t + 1;
    endtask

    task automatic model_step();
        logic req;
        if (!reset_n) begin
            model_reset();
            return;
        end
        req  = !m_s2 || soft_req;
        m_s2 = m_s1;
        m_s1 = ext_req_n;
        if (req) begin
            m_phase = 0; m_c = 0;
        end else if (m_phase == 0) begin
            if (m_c == MIN - 1) begin
                model_plan();
                m_phase = 1; m_t = 0;
            end else begin
                m_c++;
            end
        end else begin
            m_t++;
        end
        if (m_phase == 0) begin
            e_rst = 4'h0; e_busy = 1'b1; e_done = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) e_rst[k] = (rise_at[k] >= 0) && (m_t >= rise_at[k]);
            e_done = (m_t == done_at);
            e_busy = (m_t < run_at);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        model_step();
        @(negedge clock);
        chk("model_rst_n", 32'(domain_rst_n), 32'(e_rst));
        chk("model_busy", 32'(seq_busy), 32'(e_busy));
        chk("model_done", 32'(seq_done), 32'(e_done));
    endtask

    task automatic do_reset(input logic [3:0] mask, input logic [7:0] gap);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("reset_rst_n", 32'(domain_rst_n), 32'h0);
        chk("reset_busy", 32'(seq_busy), 32'h1);
        chk("reset_done", 32'(seq_done), 32'h0);
        model_reset();
        tick();
        tick();
        domain_mask = mask;
        gap_cycles  = gap;
        reset_n     = 1'b1;
        cyc         = 0;
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] gap;
        logic [3:0] fin;
        int         done_cyc;
        int         busy_cyc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int d_at, b_at, nd, n, ext_len;

        vecs[0] = '{4'b1111, 8'd3, 4'b1111, 27, 28};
        vecs[1] = '{4'b1010, 8'd0, 4'b1010, 21, 22};
        vecs[2] = '{4'b0000, 8'd5, 4'b0000, 21, 22};
        vecs[3] = '{4'b0001, 8'd2, 4'b0001, 22, 23};
        vecs[4] = '{4'b1000, 8'd1, 4'b1000, 21, 22};
        vecs[5] = '{4'b0110, 8'd4, 4'b0110, 27, 28};

        model_reset();
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].mask, vecs[v].gap);
            d_at = -1; b_at = -1; nd = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (seq_done) begin
                    nd++;
                    if (d_at < 0) d_at = cyc;
                end
                if (!seq_busy && b_at < 0) b_at = cyc;
            end
            chk("vec_final", 32'(domain_rst_n), 32'(vecs[v].fin));
            chk("vec_done_cyc", 32'(d_at), 32'(vecs[v].done_cyc));
            chk("vec_done_cnt", 32'(nd), 32'd1);
            chk("vec_busy_fall", 32'(b_at), 32'(vecs[v].busy_cyc));
        end

        // Soft request in RUN restarts the whole sequence
        do_reset(4'b1111, 8'd3);
        repeat (40) tick();
        chk("run_reached", 32'(seq_busy), 32'h0);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        chk("soft_clear", 32'(domain_rst_n), 32'h0);
        chk("soft_busy", 32'(seq_busy), 32'h1);
        n = 0;
        while (!domain_rst_n[0] && n < 40) begin tick(); n++; end
        chk("soft_restart_lat", 32'(n), 32'd16);

        // One-cycle external request mid-release aborts without seq_done
        n = 0;
        while (domain_rst_n != 4'b0011 && n < 40) begin tick(); n++; end
        chk("reach_0011", 32'(domain_rst_n), 32'b0011);
        ext_req_n = 1'b0;
        tick();
        ext_req_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 2; i++) begin tick(); if (seq_done) nd++; end
        chk("ext_abort", 32'(domain_rst_n), 32'h0);
        chk("ext_no_done", 32'(nd), 32'd0);
        n = 0;
        while (!seq_done && n < 80) begin tick(); n++; end
        chk("ext_restart_done", 32'(n), 32'd25);
        chk("ext_restart_final", 32'(domain_rst_n), 32'hF);

        // reset_n mid-gap clears outputs without a clock edge
        do_reset(4'b1111, 8'd3);
        n = 0;
        while (domain_rst_n != 4'b0001 && n < 40) begin tick(); n++; end
        chk("reach_0001", 32'(domain_rst_n), 32'b0001);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_n", 32'(domain_rst_n), 32'h0);
        chk("async_busy", 32'(seq_busy), 32'h1);
        chk("async_done", 32'(seq_done), 32'h0);
        model_reset();
        tick();
        reset_n = 1'b1;
        cyc = 0;
        n = 0;
        while (!domain_rst_n[0] && n < 40) begin tick(); n++; end
        chk("async_restart_lat", 32'(n), 32'd18);

        // Randomized traffic against the schedule model
        do_reset(4'($urandom_range(0, 15)), 8'($urandom_range(0, 6)));
        ext_len = 0;
        for (int i = 0; i < 3000; i++) begin
            soft_req = ($urandom_range(0, 59) == 0);
            if (ext_len > 0) begin
                ext_req_n = 1'b0;
                ext_len--;
            end else if ($urandom_range(0, 89) == 0) begin
                ext_req_n = 1'b0;
                ext_len = $urandom_range(0, 2);
            end else begin
                ext_req_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) domain_mask = 4'($urandom_range(0, 15));
            if (m_phase == 0 && $urandom_range(0, 9) == 0) gap_cycles = 8'($urandom_range(0, 6));
            tick();
        end
        soft_req  = 1'b0;
        ext_req_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
